// File: rtl/four_bit_adder.sv
// -----------------------------------------------------------------------------
// four_bit_adder
//
// Registered 4-bit ripple-carry adder: {Co,S3,S2,S1,S0} = A + B + Cin, with a
// signed-overflow flag and a zero flag.
//
// Build option:
//   FOURBIT_IN_REG_EN  - when defined, A/B/Cin/in_valid pass through an input
//                        register stage first (latency 2 instead of 1,
//                        throughput still one result per cycle).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   A, B       in   4-bit addends (unsigned; two's complement for ovf)
//   Cin        in   carry into bit 0
//   in_valid   in   A/B/Cin are taken on a rising edge where this is high
//   S0..S3     out  registered sum bits, S0 = LSB
//   Co         out  registered carry out of bit 3
//   out_valid  out  high for one cycle per accepted input
//   ovf        out  signed overflow (carry into bit 3 XOR Co)
//   zero       out  high when the registered sum is 0000
//
// Handshake: valid-only, no ready. Every edge with the operand valid produces
// exactly one result; there is no backpressure, so the consumer must take
// each result in the cycle out_valid is high. When no operand is valid the
// result registers hold and out_valid drops to 0.
// -----------------------------------------------------------------------------
module four_bit_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  input  logic       in_valid,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       Co,
  output logic       out_valid,
  output logic       ovf,
  output logic       zero
);

  // Operands seen by the adder core (raw inputs or the input register stage).
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_cin;
  logic       op_valid;

`ifdef FOURBIT_IN_REG_EN
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       cin_q;
  logic       in_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      cin_q      <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      a_q        <= A;
      b_q        <= B;
      cin_q      <= Cin;
      in_valid_q <= in_valid;
    end
  end

  assign op_a     = a_q;
  assign op_b     = b_q;
  assign op_cin   = cin_q;
  assign op_valid = in_valid_q;
`else
  assign op_a     = A;
  assign op_b     = B;
  assign op_cin   = Cin;
  assign op_valid = in_valid;
`endif

  // Single full adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b,
                                          input logic ci);
    logic s;
    logic co;
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
    return {co, s};
  endfunction

  // Ripple chain: c0 = bit0->1, c1 = bit1->2, c2 = bit2->3 (carry into MSB).
  logic [1:0] fa0;
  logic [1:0] fa1;
  logic [1:0] fa2;
  logic [1:0] fa3;
  logic       c0;
  logic       c1;
  logic       c2;
  logic       co_comb;
  logic [3:0] sum_comb;

  always_comb begin
    fa0      = full_add(op_a[0], op_b[0], op_cin);
    c0       = fa0[1];
    fa1      = full_add(op_a[1], op_b[1], c0);
    c1       = fa1[1];
    fa2      = full_add(op_a[2], op_b[2], c1);
    c2       = fa2[1];
    fa3      = full_add(op_a[3], op_b[3], c2);
    co_comb  = fa3[1];
    sum_comb = {fa3[0], fa2[0], fa1[0], fa0[0]};
  end

  // Result registers.
  logic [3:0] sum_q, sum_d;
  logic       co_q, co_d;
  logic       ovf_q, ovf_d;
  logic       zero_q, zero_d;
  logic       out_valid_q, out_valid_d;

  always_comb begin
    sum_d       = sum_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (op_valid) begin
      sum_d       = sum_comb;
      co_d        = co_comb;
      // Signed overflow: carry into the sign bit disagrees with carry out.
      ovf_d       = c2 ^ co_comb;
      zero_d      = (sum_comb == 4'd0);
      out_valid_d = 1'b1;
    end
  end

  // zero resets to 0 (not 1) so a freshly reset block shows no flags at all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= 4'd0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign S0        = sum_q[0];
  assign S1        = sum_q[1];
  assign S2        = sum_q[2];
  assign S3        = sum_q[3];
  assign Co        = co_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_four_bit_adder.sv
// -----------------------------------------------------------------------------
// tb_four_bit_adder - self-checking bench for four_bit_adder.
// Reference model computes results with plain integer arithmetic; a queue of
// expected words models the pipeline latency (1, or 2 with FOURBIT_IN_REG_EN).
// Expected word layout: {valid, Co, S[3:0], ovf, zero}.
// -----------------------------------------------------------------------------
module tb_four_bit_adder;

`ifdef FOURBIT_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       in_valid;
  logic       s0, s1, s2, s3, co, out_valid, ovf, zero;

  always #5 clk = ~clk;

  four_bit_adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a),
    .B        (b),
    .Cin      (cin),
    .in_valid (in_valid),
    .S0       (s0),
    .S1       (s1),
    .S2       (s2),
    .S3       (s3),
    .Co       (co),
    .out_valid(out_valid),
    .ovf      (ovf),
    .zero     (zero)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [6:0] m_res;    // held {Co,S,ovf,zero}
  logic       m_v;
  int         total = 0;
  int         bad   = 0;

  function automatic logic [7:0] model(input logic v, input logic [3:0] ai,
                                       input logic [3:0] bi, input logic ci);
    int u, sa, sb, sr;
    logic [3:0] s;
    logic c, o, z;
    u  = int'(ai) + int'(bi) + int'(ci);
    sa = (ai >= 4'd8) ? int'(ai) - 16 : int'(ai);
    sb = (bi >= 4'd8) ? int'(bi) - 16 : int'(bi);
    sr = sa + sb + int'(ci);
    s  = 4'(u % 16);
    c  = (u >= 16);
    o  = (sr > 7) || (sr < -8);
    z  = (s == 4'd0);
    return {v, c, s, o, z};
  endfunction

  function automatic logic [7:0] observed();
    return {out_valid, co, s3, s2, s1, s0, ovf, zero};
  endfunction

  task automatic check(input string tag, input logic [7:0] want);
    logic [7:0] got;
    got = observed();
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got {v,co,s,ovf,z}=%b want %b", tag, got, want);
    end
  endtask

  // Clears the model after a reset: pipeline stages before the output hold
  // invalid (reset) contents.
  task automatic model_reset();
    exp_q.delete();
    m_res = '0;
    m_v   = 1'b0;
    for (int i = 0; i < LAT - 1; i++) exp_q.push_back(8'd0);
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic v, input logic [3:0] ai,
                      input logic [3:0] bi, input logic ci);
    logic [7:0] w;
    @(negedge clk);
    in_valid = v;
    a        = ai;
    b        = bi;
    cin      = ci;
    exp_q.push_back(model(v, ai, bi, ci));
    @(posedge clk);
    w = exp_q.pop_front();
    if (w[7]) m_res = w[6:0];
    m_v = w[7];
    #1;
    check(tag, {m_v, m_res});
  endtask

  // Asserts reset between edges, checks immediate clear, then releases.
  task automatic mid_reset();
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_rst_immediate", 8'd0);
    @(posedge clk);
    #1;
    check("rst_held", 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    a        = 4'd0;
    b        = 4'd0;
    cin      = 1'b0;
    in_valid = 1'b0;
    #12;
    check("reset_state", 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Directed corner cases.
    step("a9_b8",        1'b1, 4'd9,  4'd8,  1'b0);
    step("carry_15_1",   1'b1, 4'd15, 4'd1,  1'b0);
    step("carry_15_15c", 1'b1, 4'd15, 4'd15, 1'b1);
    step("ovf_7_1",      1'b1, 4'd7,  4'd1,  1'b0);
    step("ovf_8_8",      1'b1, 4'd8,  4'd8,  1'b0);
    step("a5_b6_c1",     1'b1, 4'd5,  4'd6,  1'b1);
    step("drain0",       1'b0, 4'd0,  4'd0,  1'b0);
    step("drain1",       1'b0, 4'd0,  4'd0,  1'b0);

    // Hold: result stays while in_valid is low despite changing inputs.
    step("hold_load",    1'b1, 4'd3,  4'd4,  1'b0);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 4'd15, 4'd15, 1'b0);

    // Exhaustive sweep, Cin=0, back-to-back.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        step("sweep", 1'b1, 4'(i), 4'(j), 1'b0);

    // Mid-stream reset with valid data in flight.
    step("pre_rst_a", 1'b1, 4'd6, 4'd7, 1'b1);
    step("pre_rst_b", 1'b1, 4'd1, 4'd2, 1'b0);
    mid_reset();
    step("post_rst_2_2", 1'b1, 4'd2, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) step("post_rst_tail", 1'b0, 4'd9, 4'd9, 1'b1);

    // Randomized traffic with random valid gaps.
    for (int i = 0; i < 300; i++)
      step("random", ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    for (int i = 0; i < LAT + 1; i++) step("final_drain", 1'b0, 4'd0, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end want end");
    $fatal(1, "timeout");
  end

endmodule
